// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, state encoding and hold-register payload for the fetch sequencer.
package fetch_sequencer_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_DROP,
        ST_JALR_STALL
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] addr;
    } fetch_op_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC computation from a fetched word: JAL/branch immediates and static prediction.
// Static BTFN branch prediction is enabled by defining FETCH_BRANCH_PREDICT_EN.
module fetch_next_pc
    import fetch_sequencer_pkg::*;
(
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            pred_taken_o
);

    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_b;
    logic            br_taken;

    assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

`ifdef FETCH_BRANCH_PREDICT_EN
    // Backward branches (negative offset) are assumed to be loops and followed.
    assign br_taken = imm_b[12];
`else
    assign br_taken = 1'b0;
`endif

    always_comb begin
        next_pc_o    = pc_i + 32'd4;
        pred_taken_o = 1'b0;
        case (inst_i[6:0])
            OPC_JAL: begin
                next_pc_o    = pc_i + imm_j;
                pred_taken_o = 1'b1;
            end
            OPC_BRANCH: begin
                if (br_taken) begin
                    next_pc_o    = pc_i + imm_b;
                    pred_taken_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller feeding the fetched-op queue; one request outstanding at a time.
// Optional static branch prediction: FETCH_BRANCH_PREDICT_EN (see fetch_next_pc).
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic [31:0] inst_out,
    output logic [31:0] addr_out,
    output logic        pred_taken_out,
    output logic        inst_out_valid,
    input  logic        foq_full,
    input  logic        predict_fail,
    input  logic [31:0] redirect_addr,
    input  logic        jalr_done,
    input  logic [31:0] jalr_target
);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    fetch_op_t       hold_q;

    logic [XLEN-1:0] next_pc;
    logic            next_pred;
    logic            active;

    fetch_next_pc u_next_pc (
        .inst_i       (hold_q.inst),
        .pc_i         (hold_q.addr),
        .next_pc_o    (next_pc),
        .pred_taken_o (next_pred)
    );

    // A redirect in the same cycle suppresses both the request and the FOQ push.
    assign active         = !rst_in && rdy_in && !predict_fail;
    assign mem_req        = active && (state_q == ST_FETCH) && mem_ready;
    assign mem_addr       = mem_req ? pc_q : 32'h0;
    assign inst_out_valid = active && (state_q == ST_HOLD) && !foq_full;
    assign inst_out       = hold_q.inst;
    assign addr_out       = hold_q.addr;
    assign pred_taken_out = next_pred;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else if (rdy_in) begin
            if (predict_fail) begin
                pc_q   <= redirect_addr;
                hold_q <= '0;
                // A response still in flight must be swallowed before refetching.
                if (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !mem_valid) begin
                    state_q <= ST_DROP;
                end else begin
                    state_q <= ST_FETCH;
                end
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        if (mem_ready) begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_valid) begin
                            hold_q.inst <= mem_data;
                            hold_q.addr <= pc_q;
                            state_q     <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!foq_full) begin
                            pc_q    <= next_pc;
                            state_q <= (hold_q.inst[6:0] == OPC_JALR) ? ST_JALR_STALL : ST_FETCH;
                        end
                    end
                    ST_JALR_STALL: begin
                        if (jalr_done) begin
                            pc_q    <= jalr_target;
                            state_q <= ST_FETCH;
                        end
                    end
                    ST_DROP: begin
                        if (mem_valid) begin
                            state_q <= ST_FETCH;
                        end
                    end
                    default: state_q <= ST_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a hand-driven 2-cycle-latency memory.
module tb_fetch_sequencer;

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;
    localparam logic [31:0] JALR_W = 32'h0000_80E7;
    localparam logic [31:0] JAL_80 = 32'h0800_006F;
`ifdef FETCH_BRANCH_PREDICT_EN
    localparam logic [31:0] BR_NEXT = 32'h0000_0008;
    localparam logic        BR_PRED = 1'b1;
`else
    localparam logic [31:0] BR_NEXT = 32'h0000_0014;
    localparam logic        BR_PRED = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [31:0] inst_out;
    logic [31:0] addr_out;
    logic        pred_taken_out;
    logic        inst_out_valid;
    logic        foq_full;
    logic        predict_fail;
    logic [31:0] redirect_addr;
    logic        jalr_done;
    logic [31:0] jalr_target;

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_ready      (mem_ready),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_valid      (mem_valid),
        .mem_data       (mem_data),
        .inst_out       (inst_out),
        .addr_out       (addr_out),
        .pred_taken_out (pred_taken_out),
        .inst_out_valid (inst_out_valid),
        .foq_full       (foq_full),
        .predict_fail   (predict_fail),
        .redirect_addr  (redirect_addr),
        .jalr_done      (jalr_done),
        .jalr_target    (jalr_target)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Request at addr, answer two cycles later with word; leaves the DUT in HOLD.
    task automatic to_hold(input logic [31:0] addr, input logic [31:0] word);
        #1;
        chk("req", 32'(mem_req), 32'd1);
        chk("req_addr", mem_addr, addr);
        tick();
        chk("wait_noreq", 32'(mem_req), 32'd0);
        tick();
        mem_valid = 1'b1;
        mem_data  = word;
        tick();
        mem_valid = 1'b0;
        mem_data  = 32'h0;
    endtask

    task automatic ifetch(input logic [31:0] addr, input logic [31:0] word, input logic pred);
        to_hold(addr, word);
        #1;
        chk("push_valid", 32'(inst_out_valid), 32'd1);
        chk("push_addr", addr_out, addr);
        chk("push_inst", inst_out, word);
        chk("push_pred", 32'(pred_taken_out), 32'(pred));
        tick();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; mem_ready = 1'b1; mem_valid = 1'b0; mem_data = 32'h0;
        foq_full = 1'b0; predict_fail = 1'b0; redirect_addr = 32'h0;
        jalr_done = 1'b0; jalr_target = 32'h0;
        tick();
        tick();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_valid", 32'(inst_out_valid), 32'd0);
        chk("rst_inst", inst_out, 32'h0);
        chk("rst_addr_out", addr_out, 32'h0);
        chk("rst_pred", 32'(pred_taken_out), 32'd0);
        rst_in = 1'b0;

        // Straight-line code, one request every 4 cycles.
        ifetch(32'h0, ADDI, 1'b0);
        ifetch(32'h4, ADDI, 1'b0);
        ifetch(32'h8, ADDI, 1'b0);

        // FOQ back-pressure for 5 cycles in HOLD.
        to_hold(32'hC, ADDI);
        foq_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 32'(inst_out_valid), 32'd0);
            chk("bp_req", 32'(mem_req), 32'd0);
            tick();
        end
        foq_full = 1'b0;
        #1;
        chk("bp_push", 32'(inst_out_valid), 32'd1);
        chk("bp_push_addr", addr_out, 32'hC);
        tick();

        // Backward branch at 0x10.
        ifetch(32'h10, BEQ_M8, BR_PRED);

        // Redirect one cycle after the request; stale response is dropped.
        #1;
        chk("rd_req_addr", mem_addr, BR_NEXT);
        tick();
        predict_fail = 1'b1;
        redirect_addr = 32'h100;
        tick();
        predict_fail = 1'b0;
        #1;
        chk("drop_noreq", 32'(mem_req), 32'd0);
        mem_valid = 1'b1;
        mem_data  = ADDI;
        tick();
        mem_valid = 1'b0;
        #1;
        chk("drop_nopush", 32'(inst_out_valid), 32'd0);
        ifetch(32'h100, ADDI, 1'b0);

        // Redirect on the push cycle wins over the push.
        to_hold(32'h104, ADDI);
        predict_fail = 1'b1;
        redirect_addr = 32'h20;
        #1;
        chk("pf_push_sup", 32'(inst_out_valid), 32'd0);
        tick();
        predict_fail = 1'b0;

        // JALR stalls fetch until the target resolves.
        ifetch(32'h20, JALR_W, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("jalr_stall", 32'(mem_req), 32'd0);
            tick();
        end
        jalr_done = 1'b1;
        jalr_target = 32'h40;
        tick();
        jalr_done = 1'b0;

        // Reset mid-WAIT returns to RESET_PC.
        #1;
        chk("jalr_tgt", mem_addr, 32'h40);
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;

        // JAL at RESET_PC jumps to 0x80.
        ifetch(32'h0, JAL_80, 1'b1);

        // rdy_in low freezes everything.
        rdy_in = 1'b0;
        #1;
        chk("rdy_noreq", 32'(mem_req), 32'd0);
        tick();
        tick();
        rdy_in = 1'b1;
        to_hold(32'h80, ADDI);
        rdy_in = 1'b0;
        #1;
        chk("rdy_nopush", 32'(inst_out_valid), 32'd0);
        tick();
        rdy_in = 1'b1;
        #1;
        chk("rdy_push", 32'(inst_out_valid), 32'd1);
        chk("rdy_push_addr", addr_out, 32'h80);
        tick();
        #1;
        chk("final_req", 32'(mem_req), 32'd1);
        chk("final_addr", mem_addr, 32'h84);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller that drives the fetched-op queue (FOQ). It owns the PC and issues one 32-bit instruction read at a time to the memory/icache port. Each returned word goes to the decoder, then into the FOQ, and the sequencer computes the next PC. It backs off when the FOQ is full, redirects on `predict_fail`, and stalls after a JALR until the target resolves.

## Interface
Parameters:
- `RESET_PC`, 32'h0: PC loaded on reset.

Ports:
- `clk_in`  in  1  Single clock.
- `rst_in`  in  1  Reset, synchronous, active-high.
- `rdy_in`  in  1  Global ready. Low freezes all state; the memory port shares it.
- `mem_ready`  in  1  Memory can accept a request this cycle.
- `mem_req`  out  1  One-cycle request pulse; at most one request outstanding.
- `mem_addr`  out  32  Fetch address, valid with `mem_req`.
- `mem_valid`  in  1  One-cycle response pulse, ≥1 cycle after the request.
- `mem_data`  in  32  Instruction word, valid with `mem_valid`.
- `inst_out`  out  32  Raw instruction to the decoder/FOQ.
- `addr_out`  out  32  PC of `inst_out`.
- `pred_taken_out`  out  1  Sequencer followed the taken path after this instruction.
- `inst_out_valid`  out  1  Push strobe to the FOQ.
- `foq_full`  in  1  FOQ full.
- `predict_fail`  in  1  Flush and redirect.
- `redirect_addr`  in  32  New PC, valid with `predict_fail`.
- `jalr_done`  in  1  JALR target resolved.
- `jalr_target`  in  32  Resolved JALR target.

## Operation
- States: FETCH, WAIT, HOLD, DROP, JALR_STALL.
- **FETCH:** when `mem_ready`, pulse `mem_req` with `mem_addr`=pc, then go to WAIT.
- **WAIT:** on `mem_valid`, latch `mem_data` and the pc into the hold register, then go to HOLD.
- **HOLD:** `inst_out_valid` = !`foq_full` (combinational, so the FOQ push and the sequencer advance happen on the same edge). On push, load pc with next_pc. Next state is JALR_STALL if the opcode is JALR, otherwise FETCH.
- **JALR_STALL:** on `jalr_done`, pc ← `jalr_target`, then go to FETCH.
- **DROP:** discard the next `mem_valid`, then go to FETCH.
- next_pc, from inst[6:0] (mod 2^32):
  - JAL (1101111): pc + immJ.
  - B-type (1100011): pc + immB if predicted taken, else pc + 4.
  - All other opcodes: pc + 4.
- `predict_fail` has priority over everything except `rst_in`:
  - pc ← `redirect_addr`.
  - Hold register invalidated.
  - Next state is DROP if in WAIT with no `mem_valid` this cycle, otherwise FETCH.
- `rdy_in` low: no state change, no `mem_req`, `inst_out_valid` forced to 0.

## Timing
- Reset values: pc=`RESET_PC`, state=FETCH, all outputs 0.
- Minimum latency: request→push = memory latency + 1 cycle.
- Throughput: one instruction per (latency + 2) cycles, no overlap.
- `mem_valid` in FETCH, HOLD or JALR_STALL is ignored. This state is unreachable under the memory contract.
- `predict_fail` on the same cycle as a HOLD push: the push is suppressed (`inst_out_valid`=0); the redirect wins.
- `predict_fail` on the same cycle as `mem_valid` in WAIT: the word is discarded; next state FETCH.
- `jalr_done` outside JALR_STALL is ignored.
- Reset asserted mid-WAIT: return to FETCH. The memory controller is reset on the same edge, so no stray response arrives.

## Configuration
- `FETCH_BRANCH_PREDICT_EN` defined: static BTFN prediction.
  - B-type with immB[12]=1 (backward) is predicted taken; `pred_taken_out`=1.
- Not defined: all B-type predicted not taken; `pred_taken_out`=1 only for JAL.
- JAL is always followed in both configurations.

## Structure
- Shared include file holds:
  - Opcode constants: JAL, JALR, BRANCH.
  - State encodings.
  - `RESET_PC` default.
- One combinational sub-module, `fetch_next_pc`: inst + pc in; next_pc and pred_taken out. Contains the immJ/immB extraction and the `FETCH_BRANCH_PREDICT_EN` logic.

## Test plan
- Straight-line: ADDI words at 0x0, 0x4, 0x8 with 2-cycle memory latency → FOQ pushes addr 0x0/0x4/0x8; `mem_req` every 4 cycles.
- FOQ back-pressure: `foq_full`=1 for 5 cycles while in HOLD → `inst_out_valid`=0 and no `mem_req`; push on the first cycle `foq_full` drops.
- Redirect during WAIT: `predict_fail` with `redirect_addr`=0x100 one cycle after `mem_req` → stale `mem_valid` dropped; next `mem_addr`=0x100.
- JALR: word 0x000080E7 at 0x20 → pushed, no further `mem_req` until `jalr_done` with target 0x40; next `mem_addr`=0x40.
- Branch at 0x10 with immB=-8:
  - With `FETCH_BRANCH_PREDICT_EN`: next `mem_addr`=0x08, `pred_taken_out`=1.
  - Without: next `mem_addr`=0x14, `pred_taken_out`=0.
- JAL at 0x0 with immJ=0x80 → next `mem_addr`=0x80; `rst_in` mid-WAIT → `mem_addr`=`RESET_PC` on the next request.
